// File: rtl/xbar_mvm_if.sv
// Handshake and weight-load bundle for the crossbar matrix-vector multiplier.
// The slave side is the multiplier; the master side is the host/testbench.
interface xbar_mvm_if #(
  parameter int XH = 8,
  parameter int XW = 8,
  parameter int IW = 8,
  parameter int WW = 8,
  parameter int OW = 24
);
  localparam int RW = (XH > 1) ? $clog2(XH) : 1;

  logic [XH*IW-1:0] vector_i;
  logic             valid_i;
  logic             ready_o;
  logic             w_we;
  logic [RW-1:0]    w_row;
  logic [XW*WW-1:0] w_data;
  logic             w_ack;
  logic             relu_en;
  logic [XW*OW-1:0] vector_o;
  logic             valid_o;
  logic             ready_i;

  modport master (
    output vector_i, valid_i, w_we, w_row, w_data, relu_en, ready_i,
    input  ready_o, w_ack, vector_o, valid_o
  );

  modport slave (
    input  vector_i, valid_i, w_we, w_row, w_data, relu_en, ready_i,
    output ready_o, w_ack, vector_o, valid_o
  );
endinterface

// File: rtl/xbar_mvm.sv
// Crossbar matrix-vector multiplier: out[j] = sat(sum_i in[i]*W[i][j]), optional ReLU,
// one vector in flight, result presented LAT cycles after acceptance.
//
// state | meaning
// IDLE  | ready for a vector; weight rows may be written
// CALC  | latency counter running, weights frozen
// HOLD  | result valid, waiting for downstream ready
module xbar_mvm #(
  parameter int XH  = 8,
  parameter int XW  = 8,
  parameter int IW  = 8,
  parameter int WW  = 8,
  parameter int OW  = 24,
  parameter int LAT = 40
) (
  input  logic       clk,
  input  logic       rst,
  xbar_mvm_if.slave  bus
);
  localparam int RW = (XH > 1) ? $clog2(XH) : 1;
  localparam int PW = IW + WW + $clog2(XH);
  localparam int SW = (PW > OW) ? PW : OW;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [RW:0] XH_L = (RW+1)'(XH);
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [XH*IW-1:0] vec_q;
  logic             relu_q;
  logic [WW-1:0]    w_mem [XH][XW];
  logic [XW*OW-1:0] result;
  logic             w_hit;
  logic signed [SW-1:0]      acc;
  logic signed [IW+WW-1:0]   prod;

  assign bus.ready_o = (state == IDLE);
  assign w_hit = (state == IDLE) && bus.w_we && ({1'b0, bus.w_row} < XH_L);

  // Weights only change in IDLE, so evaluating at the end of CALC sees the accept-edge weights.
  always_comb begin
    result = '0;
    acc    = '0;
    prod   = '0;
    for (int j = 0; j < XW; j++) begin
      acc = '0;
      for (int i = 0; i < XH; i++) begin
        prod = $signed(vec_q[i*IW +: IW]) * $signed(w_mem[i][j]);
        acc  = acc + SW'(prod);
      end
      if (acc > SAT_MAX)      acc = SAT_MAX;
      else if (acc < SAT_MIN) acc = SAT_MIN;
      if (relu_q && acc[SW-1]) acc = '0;
      result[j*OW +: OW] = acc[OW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      bus.valid_o  <= 1'b0;
      bus.vector_o <= '0;
      bus.w_ack    <= 1'b0;
      vec_q        <= '0;
      relu_q       <= 1'b0;
      for (int i = 0; i < XH; i++)
        for (int j = 0; j < XW; j++)
          w_mem[i][j] <= '0;
    end else begin
      bus.w_ack <= w_hit;
      for (int i = 0; i < XH; i++)
        if (w_hit && bus.w_row == RW'(i))
          for (int j = 0; j < XW; j++)
            w_mem[i][j] <= bus.w_data[j*WW +: WW];
      case (state)
        IDLE: begin
          if (bus.valid_i) begin
            vec_q  <= bus.vector_i;
            relu_q <= bus.relu_en;
            cnt    <= CW'(LAT - 1);
            state  <= CALC;
          end
        end
        CALC: begin
          if (cnt == '0) begin
            bus.vector_o <= result;
            bus.valid_o  <= 1'b1;
            state        <= HOLD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          if (bus.ready_i) begin
            bus.valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
